flags_unit: RTL and testbench
=============================

# flags_unit

Parametrised, clocked processor-status unit for the Lapido datapath. It captures ALU condition flags under a per-opcode update mask and holds them in a register. A parametrised-depth shadow stack saves and restores the flags around interrupts and calls. It sits between the ALU flag outputs and the control unit's branch logic.

## Interface
- NFLAGS, 4, flag register width; bits [3:0] are z, c, s, o; bits above 3 are user flags written only by `load`.
- DEPTH, 4, shadow-stack entries (≥1).
- OPW, 5, ALU opcode width.
- clk  in  1  clock; all state changes on rising edge.
- r  in  1  reset, synchronous, active-high.
- we  in  1  ALU result valid; apply `flags_in` under the mask selected by `op`.
- op  in  OPW  ALU opcode of the current result.
- flags_in  in  4  ALU flags {o,s,c,z}.
- load  in  1  write `load_data` into the whole flag register.
- load_data  in  NFLAGS  value for `load`.
- push  in  1  save the current flag register to the stack.
- pop  in  1  restore the flag register from the top of the stack.
- clr_err  in  1  clear `stk_err`.
- flags_out  out  NFLAGS  flag register.
- stk_empty  out  1  stack holds 0 entries.
- stk_full  out  1  stack holds DEPTH entries.
- stk_err  out  1  sticky stack overflow/underflow error.

## Operation
- Update mask for `we`, bit order {o,s,c,z}:
  - Arithmetic ops 00000, 00001, 00011, 00100, 00101, 00110 and 01001 use mask 1111.
  - Op 01000 (lsl) uses mask 0111.
  - Op 10000 (clear) uses mask 0001.
  - Logical ops 01010, 01011, 10001, 10100–10111 and 11000–11110 use mask 0101.
  - Every other opcode uses mask 0000.
  - Masked-out bits and bits ≥4 hold their value.
- Flag register next-state priority: r > pop > load > we > hold.
  - A pop that is ignored for underflow falls through to load/we.
- Stack pointer `cnt` runs 0..DEPTH.
  - push (without pop): if not full, `stack[cnt]` ← current `flags_out` (pre-update value this cycle), then cnt+1.
  - pop (without push): if not empty, flags ← `stack[cnt-1]`, then cnt−1.
  - push and pop together: stack untouched, cnt unchanged, flags follow load/we. Not an error.
- Errors:
  - push while full: ignored, `stk_err` ← 1.
  - pop while empty: ignored, `stk_err` ← 1.
  - `stk_err` clears on r or `clr_err`. If an error and `clr_err` occur together, the error wins.
- Stack contents are not cleared by r; only cnt is reset.

## Timing
- Reset values: `flags_out` = 0, cnt = 0, `stk_empty` = 1, `stk_full` = 0, `stk_err` = 0.
- Latency: `we`, `load` and `pop` are visible on `flags_out` one cycle after the sampling edge. `stk_empty`, `stk_full` and `stk_err` are registered, with the same 1-cycle latency.
- Back-to-back operations run every cycle with no bubbles. A push in cycle N followed by a pop in cycle N+1 restores the value from before cycle N.
- r asserted mid-sequence overrides all other inputs that cycle. A pending push or pop is discarded.
- `flags_out` is driven directly from the register; there is no combinational path from any input to any output.

## Test plan
- Reset then arithmetic update: assert r, then `we`=1, `op`=00101, `flags_in`=1011 → `flags_out`=1011 next cycle, `stk_empty`=1.
- Partial masks: start from `flags_out`=1111.
  - `we` with `op`=10110, `flags_in`=0000 → 1010.
  - Then `op`=01000, `flags_in`=0000 → 1000.
  - Then an undefined op such as 00010 → unchanged.
- Save/restore across an update: `flags_out`=0011; push together with `we` (`op`=00000, `flags_in`=1100) → `flags_out`=1100, cnt=1; then pop → `flags_out`=0011, `stk_empty`=1.
- Fill and overflow (DEPTH=4):
  - Four pushes → `stk_full`=1, `stk_err`=0.
  - Fifth push → `stk_err`=1, cnt stays 4.
  - `clr_err` → `stk_err`=0.
  - Four pops return the values in LIFO order.
- Underflow and priority:
  - Pop on an empty stack together with `load` (`load_data`=0110) → `flags_out`=0110, `stk_err`=1.
  - Pop on a non-empty stack together with `load` → the popped value wins.
- Reset mid-operation and NFLAGS=6:
  - r together with push and `we` → all outputs at their reset values.
  - `load_data`=110000 then `we` with `op`=00000 → bits 5:4 stay 11.

Source files
------------

// File: rtl/flags_unit.sv
`default_nettype none
// ============================================================================
// Module   : flags_unit
// Purpose  : Processor status flags with per-opcode update masks and a
//            shadow stack for saving/restoring flags around calls/interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module flags_unit #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4,
    parameter int OPW    = 5
) (
    input  logic              clk,
    input  logic              r,
    input  logic              we,
    input  logic [OPW-1:0]    op,
    input  logic [3:0]        flags_in,
    input  logic              load,
    input  logic [NFLAGS-1:0] load_data,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic [NFLAGS-1:0] flags_out,
    output logic              stk_empty,
    output logic              stk_full,
    output logic              stk_err
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Mask bit order is {o,s,c,z}; unlisted opcodes leave every flag alone.
    function automatic logic [3:0] op_mask(input logic [OPW-1:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            OPW'(5'b00000), OPW'(5'b00001), OPW'(5'b00011), OPW'(5'b00100),
            OPW'(5'b00101), OPW'(5'b00110), OPW'(5'b01001):
                m = 4'b1111;
            OPW'(5'b01000):
                m = 4'b0111;
            OPW'(5'b10000):
                m = 4'b0001;
            OPW'(5'b01010), OPW'(5'b01011), OPW'(5'b10001),
            OPW'(5'b10100), OPW'(5'b10101), OPW'(5'b10110), OPW'(5'b10111),
            OPW'(5'b11000), OPW'(5'b11001), OPW'(5'b11010), OPW'(5'b11011),
            OPW'(5'b11100), OPW'(5'b11101), OPW'(5'b11110):
                m = 4'b0101;
            default:
                m = 4'b0000;
        endcase
        return m;
    endfunction

    logic [NFLAGS-1:0] flags;
    logic [NFLAGS-1:0] flags_nxt;
    logic [NFLAGS-1:0] flags_upd;
    logic [NFLAGS-1:0] stack [0:(1<<AW)-1];
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic [3:0]        mask;
    logic              is_full;
    logic              is_empty;
    logic              push_ok;
    logic              pop_ok;
    logic              err_evt;
    logic              empty_q;
    logic              full_q;
    logic              err_q;

    assign wr_idx = AW'(cnt);
    assign rd_idx = AW'(cnt - CW'(1));
    assign mask   = op_mask(op);

    always_comb begin
        is_full   = (cnt == FULL_CNT);
        is_empty  = (cnt == '0);
        // Simultaneous push and pop cancel out and are not an error.
        push_ok   = push & ~pop & ~is_full;
        pop_ok    = pop & ~push & ~is_empty;
        err_evt   = (push & ~pop & is_full) | (pop & ~push & is_empty);

        cnt_nxt = cnt;
        if (push_ok) begin
            cnt_nxt = cnt + CW'(1);
        end else if (pop_ok) begin
            cnt_nxt = cnt - CW'(1);
        end

        flags_upd      = flags;
        flags_upd[3:0] = (flags[3:0] & ~mask) | (flags_in & mask);

        // A rejected pop falls through to load/we.
        flags_nxt = flags;
        if (pop_ok) begin
            flags_nxt = stack[rd_idx];
        end else if (load) begin
            flags_nxt = load_data;
        end else if (we) begin
            flags_nxt = flags_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            flags   <= '0;
            cnt     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            flags   <= flags_nxt;
            cnt     <= cnt_nxt;
            empty_q <= (cnt_nxt == '0);
            full_q  <= (cnt_nxt == FULL_CNT);
            if (err_evt) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    // Stack storage survives reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (!r && push_ok) begin
            stack[wr_idx] <= flags;
        end
    end

    assign flags_out = flags;
    assign stk_empty = empty_q;
    assign stk_full  = full_q;
    assign stk_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_flags_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flags_unit
// Purpose  : Self-checking bench for flags_unit against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flags_unit;

    localparam int NFLAGS = 6;
    localparam int DEPTH  = 4;
    localparam int OPW    = 5;

    logic              clk;
    logic              r;
    logic              we;
    logic [OPW-1:0]    op;
    logic [3:0]        flags_in;
    logic              load;
    logic [NFLAGS-1:0] load_data;
    logic              push;
    logic              pop;
    logic              clr_err;
    logic [NFLAGS-1:0] flags_out;
    logic              stk_empty;
    logic              stk_full;
    logic              stk_err;

    int total;
    int bad;

    logic [NFLAGS-1:0] m_flags;
    logic [NFLAGS-1:0] m_stk[$];
    bit                m_err;

    flags_unit #(
        .NFLAGS (NFLAGS),
        .DEPTH  (DEPTH),
        .OPW    (OPW)
    ) dut (
        .clk       (clk),
        .r         (r),
        .we        (we),
        .op        (op),
        .flags_in  (flags_in),
        .load      (load),
        .load_data (load_data),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .flags_out (flags_out),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_err   (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_mask(input int code);
        if (code inside {0, 1, 3, 4, 5, 6, 9})              return 4'hF;
        if (code == 8)                                      return 4'h7;
        if (code == 16)                                     return 4'h1;
        if (code inside {10, 11, 17, [20:23], [24:30]})     return 4'h5;
        return 4'h0;
    endfunction

    // Applies one clock of the programmer-visible rules to the model.
    task automatic model_edge();
        logic [NFLAGS-1:0] old;
        logic [NFLAGS-1:0] nf;
        logic [3:0]        mk;
        bit                popped;
        bit                evt;
        old    = m_flags;
        nf     = old;
        popped = 0;
        evt    = 0;
        if (r) begin
            m_flags = '0;
            m_stk.delete();
            m_err = 0;
            return;
        end
        if (push && !pop) begin
            if (m_stk.size() == DEPTH) evt = 1;
            else m_stk.push_back(old);
        end
        if (pop && !push) begin
            if (m_stk.size() == 0) evt = 1;
            else begin
                nf     = m_stk.pop_back();
                popped = 1;
            end
        end
        if (!popped) begin
            if (load) begin
                nf = load_data;
            end else if (we) begin
                mk = ref_mask(int'(op));
                for (int i = 0; i < 4; i++) nf[i] = mk[i] ? flags_in[i] : old[i];
            end
        end
        m_flags = nf;
        if (evt) m_err = 1;
        else if (clr_err) m_err = 0;
    endtask

    task automatic idle();
        r = 0; we = 0; op = '0; flags_in = '0; load = 0; load_data = '0;
        push = 0; pop = 0; clr_err = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("flags", 32'(flags_out), 32'(m_flags));
        check("empty", 32'(stk_empty), 32'(m_stk.size() == 0));
        check("full",  32'(stk_full),  32'(m_stk.size() == DEPTH));
        check("err",   32'(stk_err),   32'(m_err));
        idle();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_flags = '0;
        m_err   = 0;
        idle();
        #1;

        // Reset then arithmetic update
        r = 1; step();
        check("rst_flags", 32'(flags_out), 32'h0);
        check("rst_empty", 32'(stk_empty), 32'h1);
        we = 1; op = 5'b00101; flags_in = 4'b1011; step();
        check("arith", 32'(flags_out), 32'b001011);

        // Partial masks
        load = 1; load_data = 6'b001111; step();
        we = 1; op = 5'b10110; flags_in = 4'b0000; step();
        check("mask_logic", 32'(flags_out), 32'b001010);
        we = 1; op = 5'b01000; flags_in = 4'b0000; step();
        check("mask_lsl", 32'(flags_out), 32'b001000);
        we = 1; op = 5'b00010; flags_in = 4'b0111; step();
        check("mask_none", 32'(flags_out), 32'b001000);

        // Save/restore across an update
        load = 1; load_data = 6'b000011; step();
        push = 1; we = 1; op = 5'b00000; flags_in = 4'b1100; step();
        check("push_upd", 32'(flags_out), 32'b001100);
        pop = 1; step();
        check("pop_restore", 32'(flags_out), 32'b000011);

        // Fill and overflow
        for (int i = 1; i <= DEPTH; i++) begin
            load = 1; load_data = NFLAGS'(i); step();
            push = 1; step();
        end
        check("fill_full", 32'(stk_full), 32'h1);
        check("fill_err", 32'(stk_err), 32'h0);
        push = 1; step();
        check("ovf_err", 32'(stk_err), 32'h1);
        clr_err = 1; step();
        check("clr_err", 32'(stk_err), 32'h0);
        for (int i = DEPTH; i >= 1; i--) begin
            pop = 1; step();
            check("lifo", 32'(flags_out), 32'(i));
        end

        // Underflow and priority
        pop = 1; load = 1; load_data = 6'b000110; step();
        check("unf_load", 32'(flags_out), 32'b000110);
        check("unf_err", 32'(stk_err), 32'h1);
        clr_err = 1; push = 1; step();
        load = 1; load_data = 6'b001001; step();
        pop = 1; load = 1; load_data = 6'b111111; step();
        check("pop_wins", 32'(flags_out), 32'b000110);

        // Reset mid-operation, then user flags
        push = 1; step();
        r = 1; push = 1; we = 1; op = 5'b00000; flags_in = 4'b1111; step();
        check("midrst_flags", 32'(flags_out), 32'h0);
        check("midrst_empty", 32'(stk_empty), 32'h1);
        load = 1; load_data = 6'b110000; step();
        we = 1; op = 5'b00000; flags_in = 4'b0101; step();
        check("user_hold", 32'(flags_out), 32'b110101);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r         = ($urandom_range(0, 99) < 2);
            we        = ($urandom_range(0, 99) < 60);
            op        = OPW'($urandom);
            flags_in  = 4'($urandom);
            load      = ($urandom_range(0, 99) < 15);
            load_data = NFLAGS'($urandom);
            push      = ($urandom_range(0, 99) < 30);
            pop       = ($urandom_range(0, 99) < 28);
            clr_err   = ($urandom_range(0, 99) < 10);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
